// File: rtl/fft4_sequencer.sv
// fft4_sequencer: drives one shared combinational radix-2 butterfly through
// a 4-point DIT FFT held in an in-place register bank.
module fft4_sequencer #(
    parameter int WIDTH = 32,
    parameter logic signed [WIDTH/2-1:0] W0_RE = 16'sd32767,
    parameter logic signed [WIDTH/2-1:0] W0_IM = 16'sd0,
    parameter logic signed [WIDTH/2-1:0] W1_RE = 16'sd0,
    parameter logic signed [WIDTH/2-1:0] W1_IM = -16'sd32767
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] bf_a,
    output logic [WIDTH-1:0] bf_b,
    output logic [WIDTH-1:0] bf_w,
    input  logic [WIDTH-1:0] bf_out0,
    input  logic [WIDTH-1:0] bf_out1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam logic [WIDTH-1:0] W0 = {W0_RE, W0_IM};
    localparam logic [WIDTH-1:0] W1 = {W1_RE, W1_IM};

    typedef enum logic [2:0] {
        LOAD,
        S1_BF0,
        S1_BF1,
        S2_BF0,
        S2_BF1,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]       load_cnt;
    logic [1:0]       out_cnt;
    logic [WIDTH-1:0] bank [4];

    logic       in_fire;
    logic       out_fire;
    logic       bf_en;
    logic [1:0] idx_a;
    logic [1:0] idx_b;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && (out_cnt == 2'd3);
    assign out_idx   = out_cnt;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Results sit bit-reversed in the bank: X0,X1,X2,X3 = bank0,2,1,3.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = bank[{out_cnt[0], out_cnt[1]}];
        end
    end

    always_comb begin
        bf_en = 1'b0;
        idx_a = 2'd0;
        idx_b = 2'd0;
        bf_w  = '0;
        bf_a  = '0;
        bf_b  = '0;
        unique case (state)
            S1_BF0: begin
                bf_en = 1'b1;
                idx_a = 2'd0;
                idx_b = 2'd2;
                bf_w  = W0;
            end
            S1_BF1: begin
                bf_en = 1'b1;
                idx_a = 2'd1;
                idx_b = 2'd3;
                bf_w  = W0;
            end
            S2_BF0: begin
                bf_en = 1'b1;
                idx_a = 2'd0;
                idx_b = 2'd1;
                bf_w  = W0;
            end
            S2_BF1: begin
                bf_en = 1'b1;
                idx_a = 2'd2;
                idx_b = 2'd3;
                bf_w  = W1;
            end
            default: ;
        endcase
        if (bf_en) begin
            bf_a = bank[idx_a];
            bf_b = bank[idx_b];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD: begin
                if (in_fire && load_cnt == 2'd3) begin
                    state_nxt = S1_BF0;
                end
            end
            S1_BF0: state_nxt = S1_BF1;
            S1_BF1: state_nxt = S2_BF0;
            S2_BF0: state_nxt = S2_BF1;
            S2_BF1: state_nxt = DRAIN;
            DRAIN: begin
                if (out_fire && out_cnt == 2'd3) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
        if (abort) begin
            state_nxt = LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Both counters are 2 bits wide, so the final increment wraps to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= 2'd0;
            out_cnt  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                bank[i] <= '0;
            end
        end else if (abort) begin
            load_cnt <= 2'd0;
            out_cnt  <= 2'd0;
        end else begin
            if (in_fire) begin
                bank[load_cnt] <= in_data;
                load_cnt       <= load_cnt + 2'd1;
            end
            if (bf_en) begin
                bank[idx_a] <= bf_out0;
                bank[idx_b] <= bf_out1;
            end
            if (out_fire) begin
                out_cnt <= out_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft4_sequencer.sv
// tb_fft4_sequencer: directed frames through fft4_sequencer with an ideal
// butterfly stub that treats the +/-32767 twiddle parts as exactly +/-1.
module tb_fft4_sequencer;

    localparam logic [31:0] W0 = 32'h7fff_0000;
    localparam logic [31:0] W1 = 32'h0000_8001;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        abort     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data   = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic [1:0]  out_idx;
    logic [31:0] bf_a;
    logic [31:0] bf_b;
    logic [31:0] bf_w;
    logic [31:0] bf_out0;
    logic [31:0] bf_out1;
    logic [31:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ea [4];
    logic [31:0] eb [4];
    logic [31:0] ew [4];

    always #5 clk = ~clk;

    fft4_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .abort(abort),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .bf_a(bf_a),
        .bf_b(bf_b),
        .bf_w(bf_w),
        .bf_out0(bf_out0),
        .bf_out1(bf_out1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_idx(out_idx),
        .out_last(out_last),
        .busy(busy)
    );

    function automatic logic [31:0] cx(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    function automatic logic [31:0] bfly(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] w,
                                         input bit sub);
        logic [15:0] wr;
        logic [15:0] wi;
        logic [15:0] re;
        logic [15:0] im;
        wr = '0;
        wi = '0;
        if (w == W0) begin
            wr = b[31:16];
            wi = b[15:0];
        end else if (w == W1) begin
            wr = b[15:0];
            wi = 16'(-$signed(b[31:16]));
        end
        re = sub ? a[31:16] - wr : a[31:16] + wr;
        im = sub ? a[15:0] - wi : a[15:0] + wi;
        return {re, im};
    endfunction

    assign bf_out0 = bfly(bf_a, bf_b, bf_w, 1'b0);
    assign bf_out1 = bfly(bf_a, bf_b, bf_w, 1'b1);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_frame(input logic [31:0] s [4], input bit hold);
        for (int i = 0; i < 4; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = s[i];
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) check("load_timeout", 32'd0, 32'd1);
            @(posedge clk);
        end
        #1;
        if (hold) in_data = 32'hdead_beef;
        else in_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit probe);
        int cyc;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (out_valid) break;
            if (probe && cyc < 4) begin
                check("bf_a", bf_a, ea[cyc]);
                check("bf_b", bf_b, eb[cyc]);
                check("bf_w", bf_w, ew[cyc]);
                check("in_ready_cmp", 32'(in_ready), 32'd0);
            end
            @(posedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'd4);
    endtask

    task automatic recv_frame(input logic [31:0] e [4], input logic [3:0] pat);
        int n;
        int k;
        n = 0;
        k = 0;
        while (n < 4 && k < 40) begin
            if (k > 0) @(negedge clk);
            out_ready = pat[k % 4];
            #1;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_idx", 32'(out_idx), 32'(n));
            check("out_data", out_data, e[n]);
            check("out_last", 32'(out_last), 32'(n == 3));
            check("in_ready_drain", 32'(in_ready), 32'd0);
            @(posedge clk);
            if (out_ready) n++;
            k++;
        end
        check("xfers", 32'(n), 32'd4);
        #1;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_bf_a"}, bf_a, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f1 [4];
        logic [31:0] fj [4];
        logic [31:0] f5 [4];
        logic [31:0] x1 [4];
        logic [31:0] xj [4];
        logic [31:0] x5 [4];
        f1 = '{cx(1, 0), cx(2, 0), cx(3, 0), cx(4, 0)};
        x1 = '{cx(10, 0), cx(-2, 2), cx(-2, 0), cx(-2, -2)};
        fj = '{cx(0, 1), cx(0, 0), cx(0, 0), cx(0, 0)};
        xj = '{cx(0, 1), cx(0, 1), cx(0, 1), cx(0, 1)};
        f5 = '{cx(5, 0), cx(5, 0), cx(5, 0), cx(5, 0)};
        x5 = '{cx(20, 0), cx(0, 0), cx(0, 0), cx(0, 0)};
        ea = '{cx(1, 0), cx(2, 0), cx(4, 0), cx(-2, 0)};
        eb = '{cx(3, 0), cx(4, 0), cx(6, 0), cx(-2, 0)};
        ew = '{W0, W0, W0, W1};

        #2;
        check_idle("rst");
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_bf_b", bf_b, 32'd0);
        check("rst_bf_w", bf_w, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        out_ready = 1'b1;
        send_frame(f1, 1'b0);
        wait_drain(1'b1);
        recv_frame(x1, 4'b1111);

        send_frame(f1, 1'b0);
        wait_drain(1'b0);
        recv_frame(x1, 4'b1001);

        send_frame(f1, 1'b1);
        wait_drain(1'b0);
        recv_frame(x1, 4'b1111);
        send_frame(fj, 1'b0);
        wait_drain(1'b0);
        recv_frame(xj, 4'b1111);

        // Two samples, then an abort that also discards a third.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = cx(7, 7);
        @(posedge clk);
        @(negedge clk);
        in_data = cx(8, 8);
        @(posedge clk);
        @(negedge clk);
        in_data = cx(9, 9);
        abort   = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        send_frame(f5, 1'b0);
        wait_drain(1'b0);
        recv_frame(x5, 4'b1111);

        send_frame(f1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("rst_s2");
        #2;
        rst_n = 1'b1;
        send_frame(f5, 1'b0);
        wait_drain(1'b0);
        recv_frame(x5, 4'b1111);

        out_ready = 1'b0;
        send_frame(fj, 1'b0);
        wait_drain(1'b0);
        rst_n = 1'b0;
        #1;
        check_idle("rst_drain");
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_frame(f1, 1'b0);
        wait_drain(1'b0);
        recv_frame(x1, 4'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft4_sequencer.md
Name: fft4_sequencer

Overview:
- Sequences one shared radix-2 `butterfly` unit through a complete 4-point DIT FFT.
- Accepts 4 packed complex samples over a valid/ready stream and holds them in a 4-entry register bank.
- Issues 4 butterfly operations (2 stages × 2), updating the bank in place.
- Streams the 4 results out in natural order X0..X3.
- Sits between the sample source and downstream spectrum consumer; the butterfly stays combinational and is instantiated beside this block.

Parameters:
- WIDTH, 32, packed complex word width: {re[WIDTH-1:HALF], im[HALF-1:0]}, HALF = WIDTH/2, signed Q15 parts.
- W0_RE/W0_IM, 16'sd32767/16'sd0, twiddle W^0 (≈1+j0).
- W1_RE/W1_IM, 16'sd0/-16'sd32767, twiddle W^1 (≈0-j1).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous abort; drops the current frame
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  WIDTH  input sample, frame order x0..x3
- bf_a  out  WIDTH  butterfly A operand
- bf_b  out  WIDTH  butterfly B operand
- bf_w  out  WIDTH  butterfly twiddle {W_RE, W_IM}
- bf_out0  in  WIDTH  butterfly result A+W·B (combinational, same cycle)
- bf_out1  in  WIDTH  butterfly result A−W·B
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  FFT bin X[out_idx]
- out_idx  out  2  bin index of out_data
- out_last  out  1  high with X3
- busy  out  1  high in any state except LOAD

Behaviour:
- Clock, reset and state:
  - One clock domain.
  - rst_n low (async) forces: state=LOAD, load_cnt=0, out_cnt=0, bank[0..3]=0.
  - Reset output values: in_ready=1, out_valid=0, out_last=0, busy=0, out_idx=0, out_data=0, bf_a/bf_b/bf_w=0.
- FSM: LOAD → S1_BF0 → S1_BF1 → S2_BF0 → S2_BF1 → DRAIN → LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready edge writes bank[load_cnt] and increments load_cnt.
  - On the 4th accept, go to S1_BF0 and clear load_cnt.
  - in_valid while in_ready=0 is ignored; no sample is consumed.
- Compute states (one cycle each, in_ready=0):
  - bf_* are driven combinationally from state and bank.
  - On the clock edge, bf_out0/bf_out1 are written back.

  | State | A | B | W | bf_out0 → | bf_out1 → |
  |---|---|---|---|---|---|
  | S1_BF0 | bank0 | bank2 | W0 | bank0 | bank2 |
  | S1_BF1 | bank1 | bank3 | W0 | bank1 | bank3 |
  | S2_BF0 | bank0 | bank1 | W0 | bank0 (X0) | bank1 (X2) |
  | S2_BF1 | bank2 | bank3 | W1 | bank2 (X1) | bank3 (X3) |

  - Outside compute states, bf_a/bf_b/bf_w=0.
- Arithmetic: no width growth or scaling in this block; bank stores bf_out* verbatim. Overflow and rounding policy belong to the butterfly.
- DRAIN:
  - out_valid=1.
  - out_cnt selects bank in order bank0, bank2, bank1, bank3; out_idx=out_cnt.
  - out_data/out_idx hold stable while out_valid&&!out_ready.
  - Each accepted transfer increments out_cnt.
  - out_last=1 when out_cnt=3; the accept of X3 returns to LOAD with out_cnt=0.
- Timing:
  - No overlap: next frame load starts in the cycle after the X3 accept.
  - Latency: 4th input accept edge → out_valid high exactly 4 cycles later.
  - Full throughput: 4 load + 4 compute + 4 drain = 12 cycles/frame.
- abort:
  - Has priority over all transitions.
  - Next edge: state=LOAD, load_cnt=0, out_cnt=0, out_valid=0.
  - Bank contents are don't-care.
  - abort in the same cycle as an input accept discards that sample.
- Reset mid-frame: all progress lost; no partial output is ever emitted.

Test Plan:
- Bench uses an ideal butterfly stub (±32767 treated as exactly ±1).
- Frame x={1,2,3,4} (imag 0), out_ready=1 → X0=10+j0, X1=-2+j2, X2=-2+j0, X3=-2-j2; out_idx 0..3; out_last only on X3; out_valid rises 4 cycles after x3 accept.
- Same frame with out_ready toggled 1,0,0,1,… → out_data/out_idx stable during stalls; exactly 4 transfers; in_ready stays 0 until X3 accepted.
- in_valid held high through compute and drain → no extra samples consumed. Second frame {0+j1,0,0,0} → all four bins = 0+j1.
- Compute-cycle probe for frame {1,2,3,4} → cycle-by-cycle (bf_a,bf_b,bf_w) = (1,3,W0),(2,4,W0),(4,6,W0),(-2,-2,W1).
- abort after 2 input samples, then a full frame {5,5,5,5} → X0=20, X1=X2=X3=0; no stale data.
- rst_n pulsed low during S2_BF0 and during DRAIN → immediately in_ready=1, out_valid=0, busy=0; next frame computes correctly.
